// File: rtl/uart_rx_frame_if.sv
// Receiver-side signal bundle for uart_rx_frame: serial line and enable in,
// frame result and status flags out.
interface uart_rx_frame_if #(
   parameter int PAYLOAD_BITS = 8
);
   logic                    uart_rxd;
   logic                    uart_rx_en;
   logic                    uart_rx_valid;
   logic [PAYLOAD_BITS-1:0] uart_rx_data;
   logic                    uart_rx_break;
   logic                    uart_rx_parity_err;
   logic                    uart_rx_frame_err;

   modport master (
      input  uart_rxd, uart_rx_en,
      output uart_rx_valid, uart_rx_data, uart_rx_break,
             uart_rx_parity_err, uart_rx_frame_err
   );

   modport slave (
      output uart_rxd, uart_rx_en,
      input  uart_rx_valid, uart_rx_data, uart_rx_break,
             uart_rx_parity_err, uart_rx_frame_err
   );
endinterface

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with 3-sample majority voting, false-start
// rejection and separate parity / framing / break status.
module uart_rx_frame #(
   parameter int BIT_RATE     = 9600,
   parameter int CLK_HZ       = 50000000,
   parameter int PAYLOAD_BITS = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input logic           clk,
   input logic           resetn,
   uart_rx_frame_if.master bus
);
   localparam int CPB  = CLK_HZ / BIT_RATE;
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);
   localparam int IW   = $clog2(PAYLOAD_BITS + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              sync_q;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           bidx_q, bidx_d;
   logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
   logic                    par_q, par_d;
   logic                    stop0_q, stop0_d;
   logic [1:0]              smp_q, smp_d;
   logic                    valid_q, valid_d;
   logic [PAYLOAD_BITS-1:0] data_q, data_d;
   logic                    brk_q, brk_d;
   logic                    perr_q, perr_d;
   logic                    ferr_q, ferr_d;

   logic rxs, wrap, decide, vote, first0, pbit, brk_w, perr_w;

   assign rxs    = sync_q[1];
   assign wrap   = (cnt_q == CW'(CPB - 1));
   assign decide = (cnt_q == CW'(HALF + 1));
   // third sample is the live value, so the vote resolves in the HALF+1 cycle
   assign vote   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

   // break needs the first stop bit; with one stop bit that is the live vote
   assign first0 = (STOP_BITS == 1) ? ~vote : stop0_q;
   assign pbit   = (PARITY != 0) ? par_q : 1'b0;
   assign brk_w  = first0 & ~|shreg_q & ~pbit;
   assign perr_w = (PARITY != 0) & (^{shreg_q, par_q} ^ (PARITY == 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q  <= 2'b11;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bidx_q  <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         stop0_q <= 1'b0;
         smp_q   <= 2'b11;
         valid_q <= 1'b0;
         data_q  <= '0;
         brk_q   <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], bus.uart_rxd};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bidx_q  <= bidx_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         stop0_q <= stop0_d;
         smp_q   <= smp_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         brk_q   <= brk_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      bidx_d  = bidx_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      stop0_d = stop0_q;
      smp_d   = smp_q;
      valid_d = 1'b0;
      data_d  = data_q;
      brk_d   = brk_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;

      if (cnt_q == CW'(HALF - 1)) smp_d[0] = rxs;
      if (cnt_q == CW'(HALF))     smp_d[1] = rxs;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rxs) begin
               state_d = S_START;
               bidx_d  = '0;
               stop0_d = 1'b0;
            end
         end
         S_START: begin
            if (decide && vote) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (wrap) begin
               state_d = S_DATA;
               bidx_d  = '0;
            end
         end
         S_DATA: begin
            if (decide) begin
               shreg_d = {vote, shreg_q[PAYLOAD_BITS-1:1]};
               bidx_d  = bidx_q + 1'b1;
            end
            if (wrap && bidx_q == IW'(PAYLOAD_BITS)) begin
               state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               bidx_d  = '0;
            end
         end
         S_PARITY: begin
            if (decide) par_d = vote;
            if (wrap) begin
               state_d = S_STOP;
               bidx_d  = '0;
            end
         end
         S_STOP: begin
            if (decide) begin
               if (bidx_q == IW'(STOP_BITS - 1)) begin
                  valid_d = 1'b1;
                  data_d  = brk_w ? '0 : shreg_q;
                  brk_d   = brk_w;
                  perr_d  = perr_w & ~brk_w;
                  ferr_d  = brk_w | stop0_q | ~vote;
                  state_d = vote ? S_IDLE : S_WAIT;
                  cnt_d   = '0;
               end else begin
                  if (!vote) stop0_d = 1'b1;
                  bidx_d = bidx_q + 1'b1;
               end
            end
         end
         S_WAIT: begin
            cnt_d = '0;
            if (rxs) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // disable abandons the frame without touching the result registers
      if (!bus.uart_rx_en) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         valid_d = 1'b0;
         data_d  = data_q;
         brk_d   = brk_q;
         perr_d  = perr_q;
         ferr_d  = ferr_q;
      end
   end

   assign bus.uart_rx_valid      = valid_q;
   assign bus.uart_rx_data       = data_q;
   assign bus.uart_rx_break      = brk_q;
   assign bus.uart_rx_parity_err = perr_q;
   assign bus.uart_rx_frame_err  = ferr_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: an 8N1 and a 7E2 receiver at 16 clocks per bit,
// checked against a frame-level model, a vector table and corner sequences.
module tb_uart_rx_frame;
   localparam int BIT_RATE = 10000;
   localparam int CLK_HZ   = 160000;
   localparam int CPB      = CLK_HZ / BIT_RATE;
   localparam int HALF     = CPB / 2;

   typedef struct packed {
      logic [8:0] data;
      logic       brk;
      logic       perr;
      logic       ferr;
   } res_t;

   typedef struct {
      logic [6:0] d;
      logic       p;
      logic       s0;
      logic       s1;
      logic [6:0] ed;
      logic       eb;
      logic       ep;
      logic       ef;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   res_t got0[$];
   res_t got1[$];
   logic v0_prev = 1'b0;
   logic v1_prev = 1'b0;

   always #5 clk = ~clk;

   uart_rx_frame_if #(.PAYLOAD_BITS(8)) if0 ();
   uart_rx_frame_if #(.PAYLOAD_BITS(7)) if1 ();

   uart_rx_frame #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(8),
                   .PARITY(0), .STOP_BITS(1))
      u0 (.clk(clk), .resetn(rst_n), .bus(if0));

   uart_rx_frame #(.BIT_RATE(BIT_RATE), .CLK_HZ(CLK_HZ), .PAYLOAD_BITS(7),
                   .PARITY(2), .STOP_BITS(2))
      u1 (.clk(clk), .resetn(rst_n), .bus(if1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // result capture, plus the rule that valid is never high two cycles running
   always @(negedge clk) begin
      if (if0.uart_rx_valid) begin
         got0.push_back('{data: {1'b0, if0.uart_rx_data}, brk: if0.uart_rx_break,
                          perr: if0.uart_rx_parity_err, ferr: if0.uart_rx_frame_err});
         chk("valid0_single_cycle", {31'd0, v0_prev}, 32'd0);
      end
      if (if1.uart_rx_valid) begin
         got1.push_back('{data: {2'b0, if1.uart_rx_data}, brk: if1.uart_rx_break,
                          perr: if1.uart_rx_parity_err, ferr: if1.uart_rx_frame_err});
         chk("valid1_single_cycle", {31'd0, v1_prev}, 32'd0);
      end
      v0_prev = if0.uart_rx_valid;
      v1_prev = if1.uart_rx_valid;
   end

   // Frame-level reference: what the receiver must report for a given set of line bits
   function automatic res_t model(input logic [8:0] d, input int nbits, input int pmode,
                                  input logic p, input logic s0, input logic s1, input int nstop);
      res_t r;
      logic [8:0] dd;
      int ones;
      dd     = d & 9'((1 << nbits) - 1);
      ones   = $countones(dd) + int'(p);
      r.brk  = (dd == 9'd0) && (pmode == 0 || p == 1'b0) && (s0 == 1'b0);
      r.ferr = r.brk || !s0 || (nstop == 2 && !s1);
      r.perr = 1'b0;
      if (!r.brk && pmode != 0) r.perr = ((ones % 2) == 1) != (pmode == 1);
      r.data = r.brk ? 9'd0 : dd;
      return r;
   endfunction

   task automatic set_rxd(input int which, input logic v);
      if (which == 0) if0.uart_rxd = v;
      else            if1.uart_rxd = v;
   endtask

   // one bit time; optional single-cycle glitch on the middle voting sample
   task automatic drive_bit(input int which, input logic b, input bit g);
      for (int k = 0; k < CPB; k++) begin
         set_rxd(which, (g && k == HALF + 1) ? ~b : b);
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int which, input int ncyc);
      set_rxd(which, 1'b1);
      repeat (ncyc) @(posedge clk);
      #1;
   endtask

   task automatic send(input int which, input logic [8:0] d, input int nbits, input bit has_par,
                       input logic p, input logic s0, input logic s1, input int nstop,
                       input bit glitch);
      drive_bit(which, 1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(which, d[i], glitch);
      if (has_par) drive_bit(which, p, 1'b0);
      drive_bit(which, s0, 1'b0);
      if (nstop == 2) drive_bit(which, s1, 1'b0);
   endtask

   task automatic take(input int which, input string nm, input res_t e);
      res_t g;
      int   n;
      if (which == 0) n = got0.size();
      else            n = got1.size();
      chk({nm, ".count"}, n, 1);
      if (n > 0) begin
         if (which == 0) g = got0.pop_front();
         else            g = got1.pop_front();
         chk({nm, ".data"}, {23'd0, g.data}, {23'd0, e.data});
         chk({nm, ".break"}, {31'd0, g.brk}, {31'd0, e.brk});
         chk({nm, ".parity_err"}, {31'd0, g.perr}, {31'd0, e.perr});
         chk({nm, ".frame_err"}, {31'd0, g.ferr}, {31'd0, e.ferr});
      end
      if (which == 0) got0.delete();
      else            got1.delete();
   endtask

   task automatic chk_outs0(input string nm, input logic [7:0] d);
      @(negedge clk);
      chk({nm, ".valid"}, {31'd0, if0.uart_rx_valid}, 32'd0);
      chk({nm, ".data"}, {24'd0, if0.uart_rx_data}, {24'd0, d});
      chk({nm, ".flags"}, {29'd0, if0.uart_rx_break, if0.uart_rx_parity_err,
                           if0.uart_rx_frame_err}, 32'd0);
   endtask

   vec_t vt[10];
   res_t ok81;

   initial begin
      vt[0] = '{7'h55, 1'b0, 1'b1, 1'b1, 7'h55, 1'b0, 1'b0, 1'b0};
      vt[1] = '{7'h55, 1'b1, 1'b1, 1'b1, 7'h55, 1'b0, 1'b1, 1'b0};
      vt[2] = '{7'h7F, 1'b1, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b0, 1'b0};
      vt[3] = '{7'h7F, 1'b0, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b1, 1'b0};
      vt[4] = '{7'h00, 1'b0, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0};
      vt[5] = '{7'h2A, 1'b1, 1'b1, 1'b0, 7'h2A, 1'b0, 1'b0, 1'b1};
      vt[6] = '{7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1};
      vt[7] = '{7'h00, 1'b0, 1'b0, 1'b1, 7'h00, 1'b1, 1'b0, 1'b1};
      vt[8] = '{7'h01, 1'b1, 1'b0, 1'b1, 7'h01, 1'b0, 1'b0, 1'b1};
      vt[9] = '{7'h00, 1'b1, 1'b0, 1'b1, 7'h00, 1'b0, 1'b1, 1'b1};
      ok81  = '{data: 9'h081, brk: 1'b0, perr: 1'b0, ferr: 1'b0};

      rst_n = 1'b0;
      if0.uart_rxd = 1'b1; if0.uart_rx_en = 1'b1;
      if1.uart_rxd = 1'b1; if1.uart_rx_en = 1'b1;
      repeat (3) @(posedge clk);
      chk_outs0("reset0", 8'h00);
      chk("reset1.valid", {31'd0, if1.uart_rx_valid}, 32'd0);
      chk("reset1.data", {25'd0, if1.uart_rx_data}, 32'd0);
      chk("reset1.flags", {29'd0, if1.uart_rx_break, if1.uart_rx_parity_err,
                           if1.uart_rx_frame_err}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(0, 2 * CPB);

      // 8N1 random bytes with random gaps of at least one bit
      for (int i = 0; i < 100; i++) begin
         logic [8:0] d;
         d = 9'($urandom_range(0, 255));
         send(0, d, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
         take(0, "rand8n1", model(d, 8, 0, 1'b0, 1'b1, 1'b1, 1));
         idle(0, CPB + int'($urandom_range(0, 2 * CPB)));
      end

      // 7E2 vector table
      for (int i = 0; i < 10; i++) begin
         send(1, {2'b0, vt[i].d}, 7, 1'b1, vt[i].p, vt[i].s0, vt[i].s1, 2, 1'b0);
         take(1, $sformatf("vec7e2[%0d]", i),
              '{data: {2'b0, vt[i].ed}, brk: vt[i].eb, perr: vt[i].ep, ferr: vt[i].ef});
         idle(1, 2 * CPB);
      end

      // 7E2 random frames, including bad parity and bad stop bits
      for (int i = 0; i < 30; i++) begin
         logic [8:0] d;
         logic p, s0, s1;
         d  = 9'($urandom_range(0, 127));
         p  = 1'($urandom_range(0, 1));
         s0 = ($urandom_range(0, 3) != 0);
         s1 = ($urandom_range(0, 3) != 0);
         send(1, d, 7, 1'b1, p, s0, s1, 2, 1'b0);
         take(1, "rand7e2", model(d, 7, 2, p, s0, s1, 2));
         idle(1, 2 * CPB);
      end

      // back-to-back frames with no idle gap
      for (int i = 0; i < 3; i++) begin
         logic [8:0] d;
         d = 9'($urandom_range(0, 255));
         send(0, d, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
         take(0, "b2b", model(d, 8, 0, 1'b0, 1'b1, 1'b1, 1));
      end
      idle(0, 2 * CPB);

      // stop bit low, line held low three bit times, then a clean byte
      send(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0);
      drive_bit(0, 1'b0, 1'b0);
      drive_bit(0, 1'b0, 1'b0);
      idle(0, 2 * CPB);
      take(0, "stopfault", '{data: 9'h0A5, brk: 1'b0, perr: 1'b0, ferr: 1'b1});
      send(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
      idle(0, CPB);
      take(0, "after_stopfault", '{data: 9'h03C, brk: 1'b0, perr: 1'b0, ferr: 1'b0});

      // short low pulse on an idle line is a false start
      set_rxd(0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      idle(0, 3 * CPB);
      chk("false_start.count", got0.size(), 0);

      // single-cycle glitch on a voting sample inside every data bit
      send(0, 9'h0F0, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
      idle(0, CPB);
      take(0, "glitch_f0", '{data: 9'h0F0, brk: 1'b0, perr: 1'b0, ferr: 1'b0});

      // break: 20 bit times low gives exactly one result
      set_rxd(0, 1'b0);
      repeat (20 * CPB) @(posedge clk);
      #1;
      take(0, "break", '{data: 9'h000, brk: 1'b1, perr: 1'b0, ferr: 1'b1});
      idle(0, 2 * CPB);
      chk("break.no_second", got0.size(), 0);
      send(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
      idle(0, CPB);
      take(0, "after_break", '{data: 9'h03C, brk: 1'b0, perr: 1'b0, ferr: 1'b0});

      // enable dropped mid-byte
      drive_bit(0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 1'b0);
      if0.uart_rx_en = 1'b0;
      drive_bit(0, 1'b1, 1'b0);
      if0.uart_rx_en = 1'b1;
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b1, 1'b0);
      idle(0, 2 * CPB);
      chk("en_abort.count", got0.size(), 0);
      chk_outs0("en_abort.hold", 8'h3C);
      send(0, 9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
      idle(0, CPB);
      take(0, "after_en_abort", ok81);

      // reset pulsed mid-byte
      drive_bit(0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, 1'b0);
      rst_n = 1'b0;
      chk_outs0("rst_abort", 8'h00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) drive_bit(0, 1'b1, 1'b0);
      idle(0, 2 * CPB);
      chk("rst_abort.count", got0.size(), 0);
      chk_outs0("rst_abort.after", 8'h00);
      send(0, 9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
      idle(0, CPB);
      take(0, "after_rst_abort", ok81);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
